// File: rtl/onewire_pkg.sv
// Shared encodings, FSM states and microsecond phase constants for the one-wire engine.
package onewire_pkg;

   typedef enum logic [1:0] {
      OpReset = 2'd0,
      OpWrite = 2'd1,
      OpRead  = 2'd2,
      OpRsvd  = 2'd3
   } onewire_op_e;

   typedef enum logic [2:0] {
      StIdle,
      StRstLow,
      StRstWait,
      StRstTail,
      StSlotLow,
      StSlotHigh,
      StDone
   } onewire_state_e;

   localparam logic [9:0] T_RST_LOW     = 10'd480;
   localparam logic [9:0] T_PRES_SAMPLE = 10'd70;
   localparam logic [9:0] T_RST_TAIL    = 10'd410;
   localparam logic [9:0] T_SLOT        = 10'd70;
   localparam logic [9:0] T_W1_LOW      = 10'd6;
   localparam logic [9:0] T_W0_LOW      = 10'd60;
   localparam logic [9:0] T_RD_SAMPLE   = 10'd15;

endpackage

// File: rtl/onewire_byte_io_if.sv
// Command/response channel between the control logic (master) and the one-wire engine (slave).
interface onewire_byte_io_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_presence;
   logic       rsp_bus_err;

   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_bus_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_bus_err
   );
endinterface

// File: rtl/onewire_crc8.sv
// Serial Dallas CRC-8 (reflected poly 0x8C, init 0), one bit per enable.
module onewire_crc8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [7:0] crc_out
);
   logic [7:0] crc_q, crc_d;
   logic       fb;

   always_comb begin
      fb    = crc_q[0] ^ bit_in;
      crc_d = crc_q;
      if (clr) begin
         crc_d = '0;
      end else if (en) begin
         crc_d = {1'b0, crc_q[7:1]} ^ (fb ? 8'h8C : 8'h00);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) crc_q <= '0;
      else      crc_q <= crc_d;
   end

   assign crc_out = crc_q;
endmodule

// File: rtl/onewire_byte_io.sv
// One-wire bus master: reset/presence, byte write and byte read slots timed from a 1 us tick.
// Optional CRC-8 of read bits and crc_zero port when ONEWIRE_CRC_EN is defined.
module onewire_byte_io
   import onewire_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 12_000_000
) (
   input  logic               clk,
   input  logic               rst,
   onewire_byte_io_if.slave   bus,
   input  logic               I_ONE_WIRE,
   output logic               O_ONE_WIRE
`ifdef ONEWIRE_CRC_EN
   ,
   output logic               crc_zero
`endif
);
   localparam int unsigned Div = CLK_FREQ_HZ / 1_000_000;

   onewire_state_e state_q, state_d;
   onewire_op_e    op_q, op_d;
   logic [15:0]    presc_q;
   logic [9:0]     us_q, us_d, low_time;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     sh_q, sh_d;
   logic [1:0]     sync_q;
   logic           pres_q, pres_d, o_q, us_tick, line, rd_sample;
   logic           rsp_valid_q, rsp_presence_q, rsp_bus_err_q;
   logic [7:0]     rsp_data_q;

   assign line      = sync_q[1];
   assign us_tick   = (presc_q == 16'(Div - 1));
   assign low_time  = (op_q == OpWrite && !sh_q[0]) ? T_W0_LOW : T_W1_LOW;
   assign rd_sample = (state_q == StSlotHigh) && (op_q == OpRead) && us_tick &&
                      (us_q == T_RD_SAMPLE - 10'd1);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      us_d    = us_tick ? us_q + 10'd1 : us_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      pres_d  = pres_q;
      unique case (state_q)
         StIdle: begin
            us_d = '0;
            if (bus.cmd_valid) begin
               op_d  = onewire_op_e'(bus.cmd_op);
               sh_d  = bus.cmd_data;
               bit_d = '0;
               unique case (op_d)
                  OpReset:        state_d = StRstLow;
                  OpWrite, OpRead: state_d = StSlotLow;
                  default:        state_d = StDone;
               endcase
            end
         end
         StRstLow: if (us_tick && us_q == T_RST_LOW - 10'd1) begin
            state_d = StRstWait;
            us_d    = '0;
         end
         StRstWait: if (us_tick && us_q == T_PRES_SAMPLE - 10'd1) begin
            pres_d  = ~line;
            state_d = StRstTail;
            us_d    = '0;
         end
         StRstTail: if (us_tick && us_q == T_RST_TAIL - 10'd1) state_d = StDone;
         // us_q keeps running across the low/high split so the slot end is always T_SLOT
         StSlotLow: if (us_tick && us_q == low_time - 10'd1) state_d = StSlotHigh;
         StSlotHigh: begin
            if (rd_sample) sh_d = {line, sh_q[7:1]};
            if (us_tick && us_q == T_SLOT - 10'd1) begin
               us_d = '0;
               if (op_q == OpWrite) sh_d = {1'b0, sh_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = StDone;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  state_d = StSlotLow;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= StIdle;
         op_q           <= OpReset;
         presc_q        <= '0;
         us_q           <= '0;
         bit_q          <= '0;
         sh_q           <= '0;
         sync_q         <= 2'b11;
         pres_q         <= 1'b0;
         o_q            <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_data_q     <= '0;
         rsp_presence_q <= 1'b0;
         rsp_bus_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         presc_q     <= us_tick ? 16'd0 : presc_q + 16'd1;
         us_q        <= us_d;
         bit_q       <= bit_d;
         sh_q        <= sh_d;
         sync_q      <= {sync_q[0], I_ONE_WIRE};
         pres_q      <= pres_d;
         o_q         <= (state_q == StRstLow) || (state_q == StSlotLow);
         rsp_valid_q <= (state_d == StDone);
         // Response fields load on entry to DONE so they are valid alongside rsp_valid
         if (state_d == StDone) begin
            rsp_bus_err_q <= ~line;
            if (op_d == OpRead)  rsp_data_q     <= sh_q;
            if (op_d == OpReset) rsp_presence_q <= pres_q;
         end
      end
   end

   assign O_ONE_WIRE       = o_q;
   assign bus.cmd_ready    = (state_q == StIdle);
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.rsp_presence = rsp_presence_q;
   assign bus.rsp_bus_err  = rsp_bus_err_q;

`ifdef ONEWIRE_CRC_EN
   logic [7:0] crc;
   logic       crc_clr;

   assign crc_clr = (state_q == StIdle) && bus.cmd_valid && (bus.cmd_op == OpReset);

   onewire_crc8 u_crc (
      .clk     (clk),
      .rst     (rst),
      .clr     (crc_clr),
      .en      (rd_sample),
      .bit_in  (line),
      .crc_out (crc)
   );

   assign crc_zero = (crc == 8'h00);
`endif
endmodule

// File: tb/tb_onewire_byte_io.sv
// Directed bench for onewire_byte_io with a small mock slave on the open-drain line.
module tb_onewire_byte_io;
   import onewire_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic O_ONE_WIRE;
   logic I_ONE_WIRE;
`ifdef ONEWIRE_CRC_EN
   logic crc_zero;
`endif

   onewire_byte_io_if bus_if ();

   onewire_byte_io #(
      .CLK_FREQ_HZ (1_000_000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_if.slave),
      .I_ONE_WIRE (I_ONE_WIRE),
      .O_ONE_WIRE (O_ONE_WIRE)
`ifdef ONEWIRE_CRC_EN
      ,
      .crc_zero   (crc_zero)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Mock slave: presence pulse 30..150 us after a long reset pulse, read bits on slot starts.
   logic       pres_en = 1'b0;
   logic       rd_en   = 1'b0;
   logic       stuck   = 1'b0;
   logic [7:0] rd_byte = 8'h00;
   logic       o_prev  = 1'b0;
   int         hi_cnt  = 0;
   int         pres_t  = 0;
   int         hold    = 0;
   int         bitidx  = 0;
   logic       slave_pull;

   assign slave_pull = (hold > 0) || (pres_t >= 30 && pres_t < 150) || stuck;
   assign I_ONE_WIRE = ~(O_ONE_WIRE | slave_pull);

   always @(posedge clk) begin
      o_prev <= O_ONE_WIRE;
      hi_cnt <= O_ONE_WIRE ? hi_cnt + 1 : 0;
      if (pres_en && o_prev && !O_ONE_WIRE && hi_cnt >= 400) pres_t <= 1;
      else if (pres_t > 0 && pres_t < 200)                   pres_t <= pres_t + 1;
      else                                                   pres_t <= 0;
      if (rd_en && O_ONE_WIRE && !o_prev) begin
         hold   <= rd_byte[bitidx] ? 0 : 30;
         bitidx <= (bitidx + 1) % 8;
      end else if (hold > 0) begin
         hold <= hold - 1;
      end
   end

   int plen[16];
   int pstart[16];
   int np;

   task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
      int n = 0;
      while (!bus_if.cmd_ready && n < 2000) begin
         @(posedge clk); #1; n++;
      end
      if (!bus_if.cmd_ready) begin
         checks++; errors++;
         $display("FAIL ready_timeout got cmd_ready=%b want 1", bus_if.cmd_ready);
      end
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_op    = op;
      bus_if.cmd_data  = data;
      @(posedge clk); #1;
      bus_if.cmd_valid = 1'b0;
   endtask

   // Cycles from acceptance to rsp_valid, recording O_ONE_WIRE pulse starts and widths.
   task automatic wait_rsp(output int lat);
      int   n = 0;
      int   hi = 0;
      logic prev = 1'b0;
      np = 0;
      while (!bus_if.rsp_valid && n < 3000) begin
         @(posedge clk); #1; n++;
         if (O_ONE_WIRE && !prev && np < 16) begin
            pstart[np] = n;
            hi = 0;
         end
         if (O_ONE_WIRE) hi++;
         if (!O_ONE_WIRE && prev && np < 16) begin
            plen[np] = hi;
            np++;
         end
         prev = O_ONE_WIRE;
      end
      if (!bus_if.rsp_valid) begin
         checks++; errors++;
         $display("FAIL rsp_timeout got no rsp_valid after %0d cycles", n);
      end
      lat = n;
   endtask

   task automatic test_reset();
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_op    = 2'd0;
      bus_if.cmd_data  = 8'h00;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus_if.cmd_ready); end
      checks++; if (bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus_if.rsp_valid); end
      checks++; if (bus_if.rsp_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", bus_if.rsp_data); end
      checks++; if (bus_if.rsp_presence !== 1'b0) begin errors++; $display("FAIL rst_pres got %b want 0", bus_if.rsp_presence); end
      checks++; if (bus_if.rsp_bus_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", bus_if.rsp_bus_err); end
      checks++; if (O_ONE_WIRE !== 1'b0) begin errors++; $display("FAIL rst_o got %b want 0", O_ONE_WIRE); end
`ifdef ONEWIRE_CRC_EN
      checks++; if (crc_zero !== 1'b1) begin errors++; $display("FAIL rst_crc_zero got %b want 1", crc_zero); end
`endif
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_presence();
      int lat;
      pres_en = 1'b1;
      send_cmd(OpReset, 8'h00);
      wait_rsp(lat);
      checks++; if (lat < 959 || lat > 961) begin errors++; $display("FAIL pres_latency got %0d want 960", lat); end
      checks++; if (bus_if.rsp_presence !== 1'b1) begin errors++; $display("FAIL pres_flag got %b want 1", bus_if.rsp_presence); end
      checks++; if (bus_if.rsp_bus_err !== 1'b0) begin errors++; $display("FAIL pres_err got %b want 0", bus_if.rsp_bus_err); end
      checks++; if (np !== 1 || plen[0] < 479 || plen[0] > 481) begin
         errors++; $display("FAIL pres_low_pulse got n=%0d w=%0d want n=1 w=480", np, plen[0]);
      end
      checks++; if (bus_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL done_ready got %b want 0", bus_if.cmd_ready); end
      @(posedge clk); #1;
      checks++; if (bus_if.cmd_ready !== 1'b1 || bus_if.rsp_valid !== 1'b0) begin
         errors++; $display("FAIL after_done got ready=%b valid=%b want 1 0", bus_if.cmd_ready, bus_if.rsp_valid);
      end
      pres_en = 1'b0;
   endtask

   task automatic test_reset_no_slave();
      int lat;
      send_cmd(OpReset, 8'h00);
      wait_rsp(lat);
      checks++; if (lat < 959 || lat > 961) begin errors++; $display("FAIL nopres_latency got %0d want 960", lat); end
      checks++; if (bus_if.rsp_presence !== 1'b0) begin errors++; $display("FAIL nopres_flag got %b want 0", bus_if.rsp_presence); end
   endtask

   task automatic test_write_cc();
      int lat;
      int exp_w[8] = '{60, 60, 6, 6, 60, 60, 6, 6};
      send_cmd(OpWrite, 8'hCC);
      wait_rsp(lat);
      checks++; if (lat < 559 || lat > 561) begin errors++; $display("FAIL wr_latency got %0d want 560", lat); end
      checks++; if (np !== 8) begin errors++; $display("FAIL wr_pulse_count got %0d want 8", np); end
      for (int i = 0; i < 8 && i < np; i++) begin
         checks++;
         if (plen[i] < exp_w[i] - 1 || plen[i] > exp_w[i] + 1) begin
            errors++; $display("FAIL wr_width[%0d] got %0d want %0d", i, plen[i], exp_w[i]);
         end
         if (i > 0) begin
            checks++;
            if (pstart[i] - pstart[0] < 70 * i - 1 || pstart[i] - pstart[0] > 70 * i + 1) begin
               errors++; $display("FAIL wr_spacing[%0d] got %0d want %0d", i, pstart[i] - pstart[0], 70 * i);
            end
         end
      end
      checks++; if (bus_if.rsp_data !== 8'h00) begin errors++; $display("FAIL wr_data_untouched got %h want 00", bus_if.rsp_data); end
   endtask

   task automatic test_read_a5();
      int lat;
      rd_byte = 8'hA5;
      rd_en   = 1'b1;
      send_cmd(OpRead, 8'h00);
      wait_rsp(lat);
      rd_en = 1'b0;
      checks++; if (lat < 559 || lat > 561) begin errors++; $display("FAIL rd_latency got %0d want 560", lat); end
      checks++; if (bus_if.rsp_data !== 8'hA5) begin errors++; $display("FAIL rd_data got %h want a5", bus_if.rsp_data); end
      checks++; if (bus_if.rsp_bus_err !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", bus_if.rsp_bus_err); end
   endtask

   task automatic test_reserved_bus_err();
      int lat;
      stuck = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      send_cmd(OpRsvd, 8'h00);
      wait_rsp(lat);
      checks++; if (lat !== 0) begin errors++; $display("FAIL rsvd_latency got %0d want 0", lat); end
      checks++; if (bus_if.rsp_bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_low got %b want 1", bus_if.rsp_bus_err); end
      checks++; if (bus_if.rsp_data !== 8'hA5) begin errors++; $display("FAIL rsvd_data_held got %h want a5", bus_if.rsp_data); end
      stuck = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      send_cmd(OpRsvd, 8'h00);
      wait_rsp(lat);
      checks++; if (bus_if.rsp_bus_err !== 1'b0) begin errors++; $display("FAIL bus_err_high got %b want 0", bus_if.rsp_bus_err); end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      send_cmd(OpWrite, 8'h00);
      repeat (194) @(posedge clk);
      #1;
      checks++; if (O_ONE_WIRE !== 1'b1) begin errors++; $display("FAIL mid_o_before got %b want 1", O_ONE_WIRE); end
      rst = 1'b0;
      #1;
      checks++; if (O_ONE_WIRE !== 1'b0) begin errors++; $display("FAIL mid_o_release got %b want 0", O_ONE_WIRE); end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 700; i++) begin
         @(posedge clk); #1;
         if (bus_if.rsp_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_rsp got %0d pulses want 0", seen); end
      checks++; if (bus_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", bus_if.cmd_ready); end
   endtask

`ifdef ONEWIRE_CRC_EN
   task automatic test_crc();
      int         lat;
      logic [7:0] seq[9] = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
      for (int pass = 0; pass < 2; pass++) begin
         send_cmd(OpReset, 8'h00);
         wait_rsp(lat);
         rd_en = 1'b1;
         for (int b = 0; b < 9; b++) begin
            rd_byte = (pass == 1 && b == 8) ? 8'h1D : seq[b];
            send_cmd(OpRead, 8'h00);
            wait_rsp(lat);
         end
         rd_en = 1'b0;
         checks++;
         if (crc_zero !== (pass == 0)) begin
            errors++; $display("FAIL crc_zero_pass%0d got %b want %0d", pass, crc_zero, pass == 0);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_reset_presence();
      test_reset_no_slave();
      test_write_cc();
      test_read_a5();
      test_reserved_bus_err();
      test_reset_mid();
`ifdef ONEWIRE_CRC_EN
      test_crc();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
